// File: rtl/grid_line_clear_pkg.sv
// Shared playfield constants and line-clear engine state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package grid_line_clear_pkg;

  localparam int GRID_COLS  = 10;
  localparam int GRID_ROWS  = 20;
  localparam int CELL_EMPTY = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SHIFT,
    ST_CLEAR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/grid_line_clear_if.sv
// Dual-port grid_mem access bus: port A write, port B read.
// Latency: mem_q_b is valid one cycle after mem_addr_b is presented.
// Backpressure: none; the memory accepts one read and one write every cycle.
//   master: drives mem_addr_a/mem_data_a/mem_we_a/mem_addr_b, samples mem_q_b
//   slave : the memory side
interface grid_line_clear_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr_a;
  logic [DATA_WIDTH-1:0] mem_data_a;
  logic                  mem_we_a;
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic [DATA_WIDTH-1:0] mem_q_b;

  modport master (
    output mem_addr_a, mem_data_a, mem_we_a, mem_addr_b,
    input  mem_q_b
  );

  modport slave (
    input  mem_addr_a, mem_data_a, mem_we_a, mem_addr_b,
    output mem_q_b
  );
endinterface

// File: rtl/grid_line_clear_row_walker.sv
// Column counter plus running row-base register; addr = base + col.
// Latency: addr is combinational from the registered base/col.
// Backpressure: none; advances only when step/dec/load are asserted.
//   load/base_in: set base, reset col to 0 (wins over step/dec)
//   step: col += 1, wrapping to 0 after last_col
//   dec : base -= COLS (move up one row)
module grid_line_clear_row_walker #(
  parameter int ADDR_WIDTH = 8,
  parameter int COLS       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic                  step,
  input  logic                  dec,
  output logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_col
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [CW-1:0] col;

  assign last_col = (col == CW'(COLS - 1));
  assign addr     = base + ADDR_WIDTH'(col);

  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      col  <= '0;
    end else if (load) begin
      base <= base_in;
      col  <= '0;
    end else begin
      if (dec)  base <= base - ADDR_WIDTH'(COLS);
      if (step) col  <= last_col ? '0 : col + CW'(1);
    end
  end
endmodule

// File: rtl/grid_line_clear.sv
// Line-clear engine: scans rows bottom-up, drops rows above each full row, clears row 0.
// Latency: 1 + ROWS*(COLS+1) cycles start-to-done, plus r*(COLS+1)+2*COLS+1 per row removed at r.
// Backpressure: none; start is ignored outside IDLE, memory is assumed always ready.
//   clk/rst/start in; busy/done/lines_cleared out; mem: grid_mem ports A (write) and B (read)
module grid_line_clear
  import grid_line_clear_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int COLS       = GRID_COLS,
  parameter int ROWS       = GRID_ROWS,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lines_cleared,
  grid_line_clear_if.master mem
);
  localparam logic [ADDR_WIDTH-1:0] BOTTOM_BASE = ADDR_WIDTH'((ROWS - 1) * COLS);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP    = ADDR_WIDTH'(COLS);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] scan_base, scan_base_nxt;   // base address of scan row r
  logic [CNT_W-1:0]      lines_nxt;
  logic                  tail, tail_nxt;             // last cycle of a row: no read, final data returns
  logic                  full, full_nxt;
  logic                  rd_vld;                     // mem_q_b holds data for a read issued last cycle
  logic [ADDR_WIDTH-1:0] addr_b_q;

  logic                  wk_load, wk_step, wk_dec, wk_last;
  logic [ADDR_WIDTH-1:0] wk_base_in, wk_base, wk_addr;

  logic q_nz, rd_active, shift_wr;

  grid_line_clear_row_walker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .COLS       (COLS)
  ) u_walker (
    .clk      (clk),
    .rst      (rst),
    .load     (wk_load),
    .base_in  (wk_base_in),
    .step     (wk_step),
    .dec      (wk_dec),
    .base     (wk_base),
    .addr     (wk_addr),
    .last_col (wk_last)
  );

  assign q_nz      = (mem.mem_q_b != DATA_WIDTH'(CELL_EMPTY));
  assign rd_active = ((state == ST_SCAN) || (state == ST_SHIFT)) && !tail;
  assign shift_wr  = (state == ST_SHIFT) && rd_vld;

  assign busy       = (state == ST_SCAN) || (state == ST_SHIFT) || (state == ST_CLEAR);
  assign done       = (state == ST_DONE);
  assign mem.mem_addr_b = rd_active ? wk_addr : '0;
  assign mem.mem_we_a   = shift_wr || (state == ST_CLEAR);
  // Shift writes land one row below the cell read in the previous cycle.
  assign mem.mem_addr_a = (state == ST_CLEAR) ? wk_addr :
                          shift_wr            ? addr_b_q + ROW_STEP : '0;
  assign mem.mem_data_a = shift_wr ? mem.mem_q_b : '0;

  always_comb begin
    state_nxt     = state;
    scan_base_nxt = scan_base;
    lines_nxt     = lines_cleared;
    tail_nxt      = tail;
    full_nxt      = full;
    wk_load       = 1'b0;
    wk_base_in    = scan_base;
    wk_step       = 1'b0;
    wk_dec        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt     = ST_SCAN;
          scan_base_nxt = BOTTOM_BASE;
          lines_nxt     = '0;
          tail_nxt      = 1'b0;
          full_nxt      = 1'b1;
          wk_load       = 1'b1;
          wk_base_in    = BOTTOM_BASE;
        end
      end

      ST_SCAN: begin
        if (!tail) begin
          wk_step = 1'b1;
          if (wk_last) tail_nxt = 1'b1;
          if (rd_vld)  full_nxt = full & q_nz;
        end else begin
          tail_nxt = 1'b0;
          full_nxt = 1'b1;
          wk_load  = 1'b1;
          if (full && q_nz) begin
            lines_nxt = lines_cleared + CNT_W'(1);
            // Nothing sits above row 0, so a full top row goes straight to CLEAR.
            if (scan_base == '0) begin
              state_nxt  = ST_CLEAR;
              wk_base_in = '0;
            end else begin
              state_nxt  = ST_SHIFT;
              wk_base_in = scan_base - ROW_STEP;
            end
          end else if (scan_base == '0) begin
            state_nxt = ST_DONE;
          end else begin
            scan_base_nxt = scan_base - ROW_STEP;
            wk_base_in    = scan_base - ROW_STEP;
          end
        end
      end

      ST_SHIFT: begin
        // Walker base points at the source row d-1.
        if (!tail) begin
          wk_step = 1'b1;
          if (wk_last) tail_nxt = 1'b1;
        end else begin
          tail_nxt = 1'b0;
          if (wk_base == '0) state_nxt = ST_CLEAR;
          else               wk_dec    = 1'b1;
        end
      end

      ST_CLEAR: begin
        wk_step = 1'b1;
        if (wk_last) begin
          // Rescan the same row: it now holds what used to be above it.
          state_nxt  = ST_SCAN;
          wk_load    = 1'b1;
          wk_base_in = scan_base;
          full_nxt   = 1'b1;
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      scan_base     <= '0;
      lines_cleared <= '0;
      tail          <= 1'b0;
      full          <= 1'b1;
      rd_vld        <= 1'b0;
      addr_b_q      <= '0;
    end else begin
      state         <= state_nxt;
      scan_base     <= scan_base_nxt;
      lines_cleared <= lines_nxt;
      tail          <= tail_nxt;
      full          <= full_nxt;
      rd_vld        <= rd_active;
      addr_b_q      <= mem.mem_addr_b;
    end
  end
endmodule

// File: tb/tb_grid_line_clear.sv
// Bench for grid_line_clear: behavioural grid_mem, reference line-clear model, scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_grid_line_clear;
  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int CELLS  = 256;
  localparam int BUDGET = 4000;

  typedef struct {
    int lines;
    int cyc;
    int wr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;
  logic       ld;

  logic [7:0] mem       [0:CELLS-1];
  logic [7:0] init_grid [0:CELLS-1];
  logic [7:0] exp_grid  [0:CELLS-1];

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  grid_line_clear_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) mif ();

  grid_line_clear dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .mem           (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // grid_mem model: registered read, write on port A; ld bulk-loads a new grid.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= init_grid[i];
    end else if (mif.mem_we_a) begin
      mem[mif.mem_addr_a] <= mif.mem_data_a;
    end
    mif.mem_q_b <= mem[mif.mem_addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_init();
    for (int i = 0; i < CELLS; i++) init_grid[i] = 8'd0;
  endtask

  task automatic load_grid();
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // Straightforward reference: remove full rows bottom-up, recheck after each drop.
  task automatic ref_model(output int lines, output int cyc, output int wr);
    int  r;
    bit  full;
    for (int i = 0; i < CELLS; i++) exp_grid[i] = mem[i];
    lines = 0;
    cyc   = 1 + ROWS * (COLS + 1);
    wr    = 0;
    r     = ROWS - 1;
    while (r >= 0) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (exp_grid[r*COLS+c] == 8'd0) full = 1'b0;
      if (full) begin
        lines++;
        cyc += r * (COLS + 1) + COLS + (COLS + 1);
        wr  += r * COLS + COLS;
        for (int d = r; d > 0; d--)
          for (int c = 0; c < COLS; c++) exp_grid[d*COLS+c] = exp_grid[(d-1)*COLS+c];
        for (int c = 0; c < COLS; c++) exp_grid[c] = 8'd0;
      end else begin
        r--;
      end
    end
  endtask

  // Runs one pass. start is high for 'hold' cycles and again in cycle 'poke' (0 = never).
  task automatic run_pass(input string name, input int hold, input int poke);
    exp_t e;
    exp_t got;
    int   cyc, ndone, wr, t_done, mism;
    ref_model(e.lines, e.cyc, e.wr);
    sb_q.push_back(e);
    got    = '{lines: -1, cyc: -1, wr: -1};
    start  = 1'b1;
    cyc    = 0;
    ndone  = 0;
    wr     = 0;
    t_done = 0;
    for (int k = 0; k < BUDGET; k++) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc < hold) || (cyc == poke);
      if (cyc == 1) check({name, " busy_rise"}, 32'(busy), 32'd1);
      if (mif.mem_we_a) wr++;
      if (done) begin
        ndone++;
        if (t_done == 0) begin
          t_done = cyc;
          check({name, " busy_in_done"}, 32'(busy), 32'd0);
          if (sb_q.size() > 0) got = sb_q.pop_front();
          check({name, " lines_at_done"}, 32'(lines_cleared), got.lines);
        end
      end
      if (t_done != 0 && cyc >= t_done + 20) break;
    end
    start = 1'b0;
    check({name, " done_pulses"}, ndone, 32'd1);
    check({name, " pass_len"}, t_done, got.cyc);
    check({name, " writes"}, wr, got.wr);
    check({name, " lines_held"}, 32'(lines_cleared), got.lines);
    check({name, " idle_after"}, 32'(busy), 32'd0);
    mism = 0;
    for (int i = 0; i < ROWS * COLS; i++) if (mem[i] !== exp_grid[i]) mism++;
    check({name, " grid_mismatches"}, mism, 32'd0);
  endtask

  initial begin
    int found;
    rst   = 1'b1;
    start = 1'b0;
    ld    = 1'b0;
    clear_init();
    load_grid();
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst lines", 32'(lines_cleared), 32'd0);
    check("rst we_a", 32'(mif.mem_we_a), 32'd0);
    check("rst addr_a", 32'(mif.mem_addr_a), 32'd0);
    check("rst addr_b", 32'(mif.mem_addr_b), 32'd0);
    check("rst data_a", 32'(mif.mem_data_a), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty grid: 221-cycle pass, no writes.
    run_pass("empty", 1, 0);

    // Row 19 full, row 18 = 180+c. Column 0 of row 18 is left empty so the
    // row that drops into 19 is not itself full and only one line goes.
    clear_init();
    for (int c = 0; c < COLS; c++) init_grid[19*COLS+c] = 8'd1;
    for (int c = 1; c < COLS; c++) init_grid[18*COLS+c] = 8'(18*COLS + c);
    load_grid();
    run_pass("one_line", 1, 0);
    check("one_line row19 col5", 32'(mem[19*COLS+5]), 32'd185);

    // Rows 16..19 full, row 15 = {5,0,...}: four removals via rechecks.
    clear_init();
    for (int r = 16; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) init_grid[r*COLS+c] = 8'd7;
    init_grid[15*COLS] = 8'd5;
    load_grid();
    run_pass("four_lines", 1, 0);
    check("four_lines count", 32'(lines_cleared), 32'd4);
    check("four_lines row19 col0", 32'(mem[19*COLS]), 32'd5);

    // Row 19 almost full: nothing removed.
    clear_init();
    for (int c = 0; c < COLS - 1; c++) init_grid[19*COLS+c] = 8'd3;
    load_grid();
    run_pass("near_full", 1, 0);

    // Top row full: cleared with no shift.
    clear_init();
    for (int c = 0; c < COLS; c++) init_grid[c] = 8'd9;
    load_grid();
    run_pass("top_row", 1, 0);

    // Reset in the middle of SHIFT.
    clear_init();
    for (int c = 0; c < COLS; c++) init_grid[19*COLS+c] = 8'd2;
    for (int c = 0; c < COLS; c += 2) init_grid[18*COLS+c] = 8'd4;
    load_grid();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 500; k++) begin
      if (mif.mem_we_a) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("shift_seen", found, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst done", 32'(done), 32'd0);
    check("mid_rst we_a", 32'(mif.mem_we_a), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_pass("after_rst", 1, 0);

    // start held for 3 cycles and re-pulsed while busy: one pass only.
    clear_init();
    for (int c = 0; c < COLS; c++) init_grid[10*COLS+c] = 8'd6;
    init_grid[9*COLS+3] = 8'd1;
    load_grid();
    run_pass("held_start", 3, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
